// File: rtl/fft_bram_reader.sv
// fft_bram_reader
//   Streams a complete FFT frame out of a pair of re/im BRAMs (port B) onto an
//   AXI-Stream master. Entries are read in (bin, mic) order with mic fastest.
//   Read data lands in a small prefetch FIFO. Reads are throttled so that the
//   FIFO occupancy plus the reads still in flight never exceeds the FIFO depth.
//   As a result no returning BRAM word can ever be dropped, whatever tready does.
//
// Optional feature (compile-time macro FFT_BRAM_READER_POWER_EN):
//   Adds m_axis_tpower = re[23:0]^2 + im[23:0]^2, aligned with its beat. It
//   costs one extra register stage between BRAM capture and the FIFO.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   frame_start           1-cycle pulse: the BRAMs hold a complete frame
//   busy                  frame in progress (accept .. last beat accepted)
//   overrun               sticky: frame_start arrived while busy
//   bram_addr, bram_en    byte address (step 4) and read enable to the BRAMs
//   bram_dout_re/_im      read data, RD_LAT cycles after bram_en
//   m_axis_tdata          {im, re}
//   m_axis_tuser          [15:3] bin index, [2:0] mic index
//   m_axis_tvalid/tready/tlast  AXI-Stream handshake, tlast on the final beat
//   m_axis_tpower         (power build only) squared magnitude of the beat
module fft_bram_reader #(
  parameter int NUM_BINS   = 256,
  parameter int NUM_MICS   = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  output logic               busy,
  output logic               overrun,
  output logic [31:0]        bram_addr,
  output logic               bram_en,
  input  logic signed [31:0] bram_dout_re,
  input  logic signed [31:0] bram_dout_im,
  output logic [63:0]        m_axis_tdata,
  output logic [15:0]        m_axis_tuser,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
`ifdef FFT_BRAM_READER_POWER_EN
  ,
  output logic [47:0]        m_axis_tpower
`endif
);

  localparam int TOTAL = NUM_BINS * NUM_MICS;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int MIC_W = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TAG_W = 17;  // {last, tuser[15:0]}
`ifdef FFT_BRAM_READER_POWER_EN
  localparam int ENT_W = 48 + TAG_W + 64;
`else
  localparam int ENT_W = TAG_W + 64;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
  localparam logic [MIC_W-1:0] MIC_LAST = MIC_W'(NUM_MICS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

`ifdef FFT_BRAM_READER_POWER_EN
  // Signed 24-bit squares, summed as an unsigned 48-bit magnitude.
  function automatic logic [47:0] power_of(input logic signed [31:0] re,
                                           input logic signed [31:0] im);
    logic signed [23:0] re_s, im_s;
    logic signed [47:0] re_sq, im_sq;
    re_s  = re[23:0];
    im_s  = im[23:0];
    re_sq = re_s * re_s;
    im_sq = im_s * im_s;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction
`endif

  state_t              state;
  logic [CNT_W-1:0]    rd_cnt;
  logic [BIN_W-1:0]    bin_cnt;
  logic [MIC_W-1:0]    mic_cnt;
  logic                issue;
  logic [OCC_W:0]      pending;
  logic [TAG_W-1:0]    tag_in;

  logic [RD_LAT-1:0]   vld_p0;
  logic [TAG_W-1:0]    tag_p0 [RD_LAT];
`ifdef FFT_BRAM_READER_POWER_EN
  logic                vld_p1;
  logic [TAG_W-1:0]    tag_p1;
  logic signed [31:0]  re_p1;
  logic signed [31:0]  im_p1;
`endif

  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [OCC_W-1:0]    occ;
  logic                push;
  logic                pop;
  logic [ENT_W-1:0]    push_data;
  logic [ENT_W-1:0]    head;

  // Occupancy plus every read still travelling toward the FIFO.
  always_comb begin
    pending = {1'b0, occ};
    for (int i = 0; i < RD_LAT; i++)
      pending = pending + {{OCC_W{1'b0}}, vld_p0[i]};
`ifdef FFT_BRAM_READER_POWER_EN
    pending = pending + {{OCC_W{1'b0}}, vld_p1};
    // Credit this cycle's pop so the extra stage does not cost throughput;
    // the slot freed by the pop is vacated before any new read can land.
    issue = (state == S_READ) && ((pending - {{OCC_W{1'b0}}, pop}) < DEPTH_C);
`else
    issue = (state == S_READ) && (pending < DEPTH_C);
`endif
  end

  assign tag_in    = {(rd_cnt == LAST_IDX), 13'(bin_cnt), 3'(mic_cnt)};
  assign bram_en   = issue;
  assign bram_addr = 32'({rd_cnt, 2'b00});

`ifdef FFT_BRAM_READER_POWER_EN
  assign push      = vld_p1;
  assign push_data = {power_of(re_p1, im_p1), tag_p1, im_p1, re_p1};
`else
  assign push      = vld_p0[RD_LAT-1];
  assign push_data = {tag_p0[RD_LAT-1], bram_dout_im, bram_dout_re};
`endif

  // FIFO contents are not reset, so every output is gated by tvalid.
  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (occ != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? head[63:0]  : 64'd0;
  assign m_axis_tuser  = m_axis_tvalid ? head[79:64] : 16'd0;
  assign m_axis_tlast  = m_axis_tvalid && head[80];
`ifdef FFT_BRAM_READER_POWER_EN
  assign m_axis_tpower = m_axis_tvalid ? head[128:81] : 48'd0;
`endif

  // Frame sequencing and read counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      overrun <= 1'b0;
      rd_cnt  <= '0;
      bin_cnt <= '0;
      mic_cnt <= '0;
    end else begin
      if (frame_start && state != S_IDLE)
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state   <= S_READ;
            busy    <= 1'b1;
            rd_cnt  <= '0;
            bin_cnt <= '0;
            mic_cnt <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            // The counter parks on the last index until the next frame.
            if (rd_cnt == LAST_IDX) begin
              state <= S_DRAIN;
            end else begin
              rd_cnt <= rd_cnt + CNT_W'(1);
              if (mic_cnt == MIC_LAST) begin
                mic_cnt <= '0;
                bin_cnt <= bin_cnt + BIN_W'(1);
              end else begin
                mic_cnt <= mic_cnt + MIC_W'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (pop && head[80]) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: BRAM read latency line / stage p1: power / FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= '0;
`ifdef FFT_BRAM_READER_POWER_EN
      vld_p1 <= 1'b0;
`endif
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      vld_p0[0] <= issue;
      for (int i = 1; i < RD_LAT; i++)
        vld_p0[i] <= vld_p0[i-1];
`ifdef FFT_BRAM_READER_POWER_EN
      vld_p1 <= vld_p0[RD_LAT-1];
`endif
      if (push)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Data path: tags, captured samples and FIFO storage
  always_ff @(posedge clk) begin
    tag_p0[0] <= tag_in;
    for (int i = 1; i < RD_LAT; i++)
      tag_p0[i] <= tag_p0[i-1];
`ifdef FFT_BRAM_READER_POWER_EN
    tag_p1 <= tag_p0[RD_LAT-1];
    re_p1  <= bram_dout_re;
    im_p1  <= bram_dout_im;
`endif
    if (push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_fft_bram_reader.sv
`timescale 1ns/1ps
module tb_fft_bram_reader;

  localparam int NBEATS = 2048;
`ifdef FFT_BRAM_READER_POWER_EN
  localparam int LAT_MAX = 6;
`else
  localparam int LAT_MAX = 5;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               busy;
  logic               overrun;
  logic [31:0]        bram_addr;
  logic               bram_en;
  logic signed [31:0] bram_dout_re;
  logic signed [31:0] bram_dout_im;
  logic [63:0]        m_axis_tdata;
  logic [15:0]        m_axis_tuser;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
`ifdef FFT_BRAM_READER_POWER_EN
  logic [47:0]        m_axis_tpower;
`endif

  int  n_vec, n_err;
  int  exp_k, issued, popped;
  bit  mon_en, pmode;
  logic        e1;
  logic [31:0] a1;

  always #5 clk = ~clk;

  fft_bram_reader dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .busy         (busy),
    .overrun      (overrun),
    .bram_addr    (bram_addr),
    .bram_en      (bram_en),
    .bram_dout_re (bram_dout_re),
    .bram_dout_im (bram_dout_im),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
`ifdef FFT_BRAM_READER_POWER_EN
    .m_axis_tpower(m_axis_tpower),
`endif
    .m_axis_tlast (m_axis_tlast)
  );

  // Frame contents: re = index, im = -index, with two special entries for
  // the power build.
  function automatic logic signed [31:0] stim_re(input int k);
    if (pmode && k == 0) return -32'sd3;
    if (pmode && k == 1) return -32'sd8388608;
    return 32'(k);
  endfunction

  function automatic logic signed [31:0] stim_im(input int k);
    if (pmode && k == 0) return 32'sd4;
    if (pmode && k == 1) return 32'sd0;
    return 32'(-k);
  endfunction

  function automatic logic [63:0] exp_power(input int k);
    if (pmode && k == 0) return 64'd25;
    if (pmode && k == 1) return 64'd70368744177664;
    return 64'(2 * k * k);
  endfunction

  // Two-cycle-latency BRAM.
  always @(posedge clk) begin
    e1 <= bram_en;
    a1 <= bram_addr;
    if (e1) begin
      bram_dout_re <= stim_re(int'(a1 >> 2));
      bram_dout_im <= stim_im(int'(a1 >> 2));
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, return 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      if (bram_en) begin
        check_vec("rd_addr", 64'(bram_addr), 64'(issued * 4));
`ifndef FFT_BRAM_READER_POWER_EN
        check_vec("rd_room", 64'((issued - popped) < 4), 64'(1));
`endif
        issued++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check_vec("beat_data", m_axis_tdata, {stim_im(exp_k), stim_re(exp_k)});
        check_vec("beat_tag", 64'({m_axis_tlast, m_axis_tuser}),
                  64'({exp_k == NBEATS - 1, 13'(exp_k / 8), 3'(exp_k % 8)}));
`ifdef FFT_BRAM_READER_POWER_EN
        check_vec("beat_power", 64'(m_axis_tpower), exp_power(exp_k));
`endif
        if (exp_k == NBEATS - 1)
          check_vec("busy_at_last", 64'(busy), 64'(1));
        exp_k++;
        popped++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    mon_en = 1'b1;
    exp_k = 0;
    issued = 0;
    popped = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int limit, input int target, output int cyc);
    cyc = 0;
    while (exp_k < target && cyc < limit) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_vec({tag, "_busy"},    64'(busy), 64'(0));
    check_vec({tag, "_overrun"}, 64'(overrun), 64'(0));
    check_vec({tag, "_bram_en"}, 64'(bram_en), 64'(0));
    check_vec({tag, "_addr"},    64'(bram_addr), 64'(0));
    check_vec({tag, "_tvalid"},  64'(m_axis_tvalid), 64'(0));
    check_vec({tag, "_tlast"},   64'(m_axis_tlast), 64'(0));
    check_vec({tag, "_tdata"},   m_axis_tdata, 64'(0));
    check_vec({tag, "_tuser"},   64'(m_axis_tuser), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, lat, stale;
    n_vec = 0; n_err = 0;
    exp_k = 0; issued = 0; popped = 0;
    mon_en = 1'b0; pmode = 1'b0;
    rst = 1'b1; frame_start = 1'b0; m_axis_tready = 1'b0;
    repeat (3) tick();
    check_outputs_zero("rst");
    rst = 1'b0;
    repeat (2) tick();

    // Streaming frame, tready held high
    m_axis_tready = 1'b1;
    start_frame();
    check_vec("a_busy_rise", 64'(busy), 64'(1));
    lat = 0;
    while (!m_axis_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    check_vec("a_first_lat_ok", 64'(lat <= LAT_MAX), 64'(1));
    run_frame(1'b0, 5000, NBEATS, cyc);
    check_vec("a_beats", 64'(exp_k), 64'(NBEATS));
    check_vec("a_no_bubble", 64'(cyc), 64'(NBEATS));
    check_vec("a_busy_fall", 64'(busy), 64'(0));
    check_vec("a_overrun", 64'(overrun), 64'(0));
    repeat (2) tick();

    // Random backpressure
    start_frame();
    run_frame(1'b1, 20000, NBEATS, cyc);
    m_axis_tready = 1'b1;
    check_vec("b_beats", 64'(exp_k), 64'(NBEATS));
    check_vec("b_reads", 64'(issued), 64'(NBEATS));
    check_vec("b_busy_fall", 64'(busy), 64'(0));
    repeat (2) tick();

    // Stalled sink: prefetch fills, then drains seamlessly
    m_axis_tready = 1'b0;
    start_frame();
    repeat (20) tick();
    check_vec("c_reads_held", 64'(issued), 64'(4));
    check_vec("c_valid_held", 64'(m_axis_tvalid), 64'(1));
    check_vec("c_head_tuser", 64'(m_axis_tuser), 64'(0));
    m_axis_tready = 1'b1;
    run_frame(1'b0, 5000, NBEATS, cyc);
    check_vec("c_beats", 64'(exp_k), 64'(NBEATS));
    check_vec("c_seamless", 64'(cyc), 64'(NBEATS));
    repeat (2) tick();

    // frame_start while busy
    start_frame();
    run_frame(1'b0, 5000, 100, cyc);
    check_vec("d_overrun_pre", 64'(overrun), 64'(0));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_vec("d_overrun_set", 64'(overrun), 64'(1));
    run_frame(1'b0, 5000, NBEATS, cyc);
    check_vec("d_beats", 64'(exp_k), 64'(NBEATS));
    check_vec("d_overrun_held", 64'(overrun), 64'(1));
    check_vec("d_busy_fall", 64'(busy), 64'(0));
    repeat (2) tick();

    // Reset mid-frame
    start_frame();
    run_frame(1'b0, 5000, 500, cyc);
    check_vec("e_reached", 64'(exp_k), 64'(500));
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    check_outputs_zero("e_rst");
    rst = 1'b0;
    stale = 0;
    repeat (10) begin
      tick();
      stale += int'(m_axis_tvalid) + int'(bram_en);
    end
    check_vec("e_no_stale", 64'(stale), 64'(0));

    // Fresh frame from address 0; frame_start coincident with the last beat
    start_frame();
    run_frame(1'b0, 5000, NBEATS - 1, cyc);
    check_vec("f_before_last", 64'(exp_k), 64'(NBEATS - 1));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_vec("f_beats", 64'(exp_k), 64'(NBEATS));
    check_vec("f_overrun", 64'(overrun), 64'(1));
    check_vec("f_busy_fall", 64'(busy), 64'(0));
    repeat (5) tick();
    check_vec("f_no_restart_en", 64'(bram_en), 64'(0));
    check_vec("f_no_restart_busy", 64'(busy), 64'(0));
    check_vec("f_no_restart_valid", 64'(m_axis_tvalid), 64'(0));

`ifdef FFT_BRAM_READER_POWER_EN
    // Power output with hand-picked first entries
    pmode = 1'b1;
    start_frame();
    run_frame(1'b0, 5000, NBEATS, cyc);
    check_vec("g_beats", 64'(exp_k), 64'(NBEATS));
    pmode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
